// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared types and constants for the SPI master:
//             - spi_state_t : transfer sequencer states
//             - MODE0..3    : SPI mode encoding as {cpol, cpha}
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        TRANSFER = 2'd2,
        HOLD     = 2'd3
    } spi_state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : spi_clk_gen
//  Purpose  : SCLK generator. Counts CLK_DIV system clocks per phase and
//             emits a tick at the end of each phase; when edge_en is high
//             the tick also toggles SCLK and is classified as a leading or
//             trailing edge relative to the idle level captured on load.
//  Ports    : clk, rst (async, active-low)
//             run        - counter enable (low holds the counter at 0)
//             edge_en    - this tick toggles SCLK
//             load       - capture load_level as SCLK and idle level
//             tick       - end of a CLK_DIV-cycle phase
//             lead_edge  - SCLK leaves its idle level this cycle
//             trail_edge - SCLK returns to its idle level this cycle
//             sclk       - registered serial clock
//  Revision : 1.0 - initial release
// ============================================================================
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic edge_en,
    input  logic load,
    input  logic load_level,
    output logic tick,
    output logic lead_edge,
    output logic trail_edge,
    output logic sclk
);

    localparam int              CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sclk;
    logic             r_level;
    logic             w_toggle;

    assign tick       = run && (r_cnt == C_CNT_MAX);
    assign w_toggle   = tick && edge_en;
    assign lead_edge  = w_toggle && (r_sclk == r_level);
    assign trail_edge = w_toggle && (r_sclk != r_level);
    assign sclk       = r_sclk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_sclk  <= 1'b0;
            r_level <= 1'b0;
        end else begin
            if (!run || tick)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (load) begin
                r_sclk  <= load_level;
                r_level <= load_level;
            end else if (w_toggle) begin
                r_sclk <= ~r_sclk;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_gen.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_gen
//  Purpose  : Parametrised SPI master, all four CPOL/CPHA modes, NUM_SS
//             active-low selects, start/busy/done host handshake.
//             Sequence: IDLE -> SETUP (CLK_DIV) -> TRANSFER (2*DATA_W edges,
//             CLK_DIV apart) -> HOLD (CLK_DIV) -> IDLE with a done pulse.
//  Config   : SPI_LSB_FIRST_EN - adds input lsb_first (sampled with start)
//             selecting LSB-first transmit and receive bit order.
//  Ports    : clk, rst (async, active-low)
//             start, ss_sel, cpol, cpha, tx_data - request, sampled in IDLE
//             busy, done, rx_data                - host status / result
//             SCLK, MOSI, MISO, SS               - SPI bus
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master_gen #(
    parameter  int DATA_W  = 8,
    parameter  int NUM_SS  = 2,
    parameter  int CLK_DIV = 4,
    localparam int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_SS-1:0] SS
);

    import spi_pkg::*;

    localparam int               EC_W        = $clog2(2 * DATA_W + 1);
    localparam logic [EC_W-1:0]  C_EDGES     = EC_W'(2 * DATA_W);
    localparam logic [EC_W-1:0]  C_LAST_EDGE = EC_W'(2 * DATA_W - 1);
    localparam logic [SS_W:0]    C_NUM_SS    = (SS_W + 1)'(NUM_SS);

    spi_state_t        r_state, w_state_next;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_rx_sh;
    logic [DATA_W-1:0] r_rx_data;
    logic [EC_W-1:0]   r_edge_cnt;
    logic [NUM_SS-1:0] r_ss;
    logic              r_mosi;
    logic              r_done;

    logic              w_accept;
    logic              w_edge_en;
    logic              w_tick;
    logic              w_lead;
    logic              w_trail;
    logic              w_sclk;
    logic              w_shift_on_lead;
    logic              w_shift;
    logic              w_sample;
    logic [NUM_SS-1:0] w_ss_sel_n;
    logic [DATA_W-1:0] w_tx_ord;
    logic [DATA_W-1:0] w_rx_ord;

    // Requests addressing a nonexistent slave are dropped silently.
    assign w_accept = (r_state == IDLE) && start && ({1'b0, ss_sel} < C_NUM_SS);

    always_comb begin
        w_ss_sel_n = '1;
        for (int i = 0; i < NUM_SS; i++)
            w_ss_sel_n[i] = (ss_sel != SS_W'(i));
    end

`ifdef SPI_LSB_FIRST_EN
    logic              r_lsb;
    logic [DATA_W-1:0] w_tx_rev;
    logic [DATA_W-1:0] w_rx_rev;

    always_comb begin
        w_tx_rev = '0;
        w_rx_rev = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_tx_rev[i] = tx_data[DATA_W-1-i];
            w_rx_rev[i] = r_rx_sh[DATA_W-1-i];
        end
    end

    // The shifters always run MSB-first; LSB-first is a bit reversal at
    // load (transmit) and at completion (receive).
    assign w_tx_ord = lsb_first ? w_tx_rev : tx_data;
    assign w_rx_ord = r_lsb     ? w_rx_rev : r_rx_sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_lsb <= 1'b0;
        else if (w_accept)
            r_lsb <= lsb_first;
    end
`else
    assign w_tx_ord = tx_data;
    assign w_rx_ord = r_rx_sh;
`endif

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .run        (r_state != IDLE),
        .edge_en    (w_edge_en),
        .load       (w_accept),
        .load_level (cpol),
        .tick       (w_tick),
        .lead_edge  (w_lead),
        .trail_edge (w_trail),
        .sclk       (w_sclk)
    );

    // The tick closing SETUP produces SCLK edge 1; the TRANSFER tick after
    // the final edge carries no edge and moves on to HOLD.
    always_comb begin
        w_state_next = r_state;
        w_edge_en    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept)
                    w_state_next = SETUP;
            end
            SETUP: begin
                w_edge_en = 1'b1;
                if (w_tick)
                    w_state_next = TRANSFER;
            end
            TRANSFER: begin
                w_edge_en = (r_edge_cnt != C_EDGES);
                if (w_tick && (r_edge_cnt == C_EDGES))
                    w_state_next = HOLD;
            end
            HOLD: begin
                if (w_tick)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // cpha=1 shifts on leading edges and samples on trailing; cpha=0 is the
    // reverse, with no shift after the final trailing edge.
    assign w_shift_on_lead = (r_mode == MODE1) || (r_mode == MODE3);
    assign w_shift  = w_shift_on_lead ? w_lead
                                      : (w_trail && (r_edge_cnt != C_LAST_EDGE));
    assign w_sample = w_shift_on_lead ? w_trail : w_lead;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode     <= MODE0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_edge_cnt <= '0;
            r_ss       <= '1;
            r_mosi     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_mode     <= {cpol, cpha};
                // MSB goes out on SETUP entry. With cpha=0 the register is
                // pre-advanced so the first trailing edge drives the next
                // bit; with cpha=1 the first leading edge re-drives the MSB.
                r_tx_sh    <= cpha ? w_tx_ord : {w_tx_ord[DATA_W-2:0], 1'b0};
                r_mosi     <= w_tx_ord[DATA_W-1];
                r_rx_sh    <= '0;
                r_edge_cnt <= '0;
                r_ss       <= w_ss_sel_n;
            end

            if (w_lead || w_trail)
                r_edge_cnt <= r_edge_cnt + 1'b1;

            if (w_sample)
                r_rx_sh <= {r_rx_sh[DATA_W-2:0], MISO};

            if (w_shift) begin
                r_mosi  <= r_tx_sh[DATA_W-1];
                r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
            end

            if ((r_state == HOLD) && w_tick) begin
                r_done    <= 1'b1;
                r_rx_data <= w_rx_ord;
                r_ss      <= '1;
            end
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign SCLK    = w_sclk;
    assign MOSI    = r_mosi;
    assign SS      = r_ss;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master_gen
//  Purpose  : Self-checking bench for spi_master_gen (DATA_W=8, NUM_SS=3,
//             CLK_DIV=2). A behavioural SPI slave returns a chosen word and
//             records what it receives; each transfer is checked for
//             latency, select pattern, SCLK idle level and both data words.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_gen;

    localparam int DATA_W  = 8;
    localparam int NUM_SS  = 3;
    localparam int CLK_DIV = 2;
    localparam int LAT     = (2 * DATA_W + 2) * CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] ss_sel = '0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [7:0] tx_data = '0;
`ifdef SPI_LSB_FIRST_EN
    logic       lsb_first = 1'b0;
`endif
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       SCLK;
    logic       MOSI;
    logic       MISO = 1'b0;
    logic [2:0] SS;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spi_master_gen #(
        .DATA_W  (DATA_W),
        .NUM_SS  (NUM_SS),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ss_sel  (ss_sel),
        .cpol    (cpol),
        .cpha    (cpha),
        .tx_data (tx_data),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .SS      (SS)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    logic [7:0] sl_word = '0;
    logic [7:0] sl_rx   = '0;
    int         sl_idx  = 7;
    int         sl_nedge = 0;
    int         sl_nsamp = 0;
    logic       sl_prev_sclk = 1'b0;
    logic       sl_prev_act  = 1'b0;
    logic       m_cpol = 1'b0;
    logic       m_cpha = 1'b0;

    always @(negedge clk) begin
        logic act;
        logic lead;
        act = (SS != 3'b111);
        if (act && !sl_prev_act) begin
            sl_rx    = '0;
            sl_idx   = 7;
            sl_nedge = 0;
            sl_nsamp = 0;
            MISO     = sl_word[7];
        end else if (act && (SCLK != sl_prev_sclk)) begin
            sl_nedge++;
            lead = (SCLK != m_cpol);
            if (lead ^ m_cpha) begin
                sl_rx = {sl_rx[6:0], MOSI};
                sl_nsamp++;
            end else if (m_cpha) begin
                if (sl_idx >= 0) MISO = sl_word[sl_idx];
                sl_idx--;
            end else begin
                sl_idx--;
                if (sl_idx >= 0) MISO = sl_word[sl_idx];
            end
        end
        sl_prev_sclk = SCLK;
        sl_prev_act  = act;
    end

    // Called at a negedge: present a request for the next rising edge.
    task automatic start_xfer(input logic [1:0] sel, input logic pol, input logic pha,
                              input logic [7:0] tx, input logic [7:0] sw);
        m_cpol  = pol;
        m_cpha  = pha;
        sl_word = sw;
        ss_sel  = sel;
        cpol    = pol;
        cpha    = pha;
        tx_data = tx;
        start   = 1'b1;
    endtask

    // Cycle count includes the start cycle; returns at the negedge of done.
    task automatic wait_done(input logic [1:0] sel, input logic pol,
                             input logic [7:0] tx, input logic [7:0] sw, input bit inject);
        int         cyc;
        logic [2:0] exp_ss;
        exp_ss = 3'b111 & ~(3'b001 << sel);
        cyc = 0;
        @(posedge clk);
        #1;
        start   = 1'b0;
        tx_data = 8'($urandom);
        cpol    = 1'($urandom);
        cpha    = 1'($urandom);
        ss_sel  = 2'($urandom);
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_eq("busy_on", busy, 1);
                check_eq("ss_assert", SS, exp_ss);
                check_eq("sclk_idle", SCLK, pol);
            end
            if (inject && cyc == 10) begin
                start   = 1'b1;
                tx_data = 8'hFF;
            end
            if (inject && cyc == 11) start = 1'b0;
        end while (!done && cyc < 200);
        check_eq("latency", cyc, LAT);
        check_eq("rx_data", rx_data, sw);
        check_eq("mosi_word", sl_rx, tx);
        check_eq("sclk_edges", sl_nedge, 16);
        check_eq("ss_release", SS, 3'b111);
        check_eq("busy_off", busy, 0);
        check_eq("sclk_rest", SCLK, pol);
    endtask

    initial begin
        int cnt;

        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rx", rx_data, 0);
        check_eq("rst_sclk", SCLK, 0);
        check_eq("rst_mosi", MOSI, 0);
        check_eq("rst_ss", SS, 3'b111);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // All four modes with the reference pattern.
        for (int m = 0; m < 4; m++) begin
            start_xfer(2'd0, 1'(m >> 1), 1'(m), 8'hA5, 8'h3C);
            wait_done(2'd0, 1'(m >> 1), 8'hA5, 8'h3C, 1'b0);
            @(negedge clk);
            check_eq("done_width", done, 0);
            repeat (2) @(negedge clk);
        end

        // Start while busy is ignored; exactly one done.
        start_xfer(2'd1, 1'b0, 1'b0, 8'hA5, 8'h3C);
        wait_done(2'd1, 1'b0, 8'hA5, 8'h3C, 1'b1);
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check_eq("no_extra_done", cnt, 0);

        // Out-of-range select.
        start_xfer(2'd3, 1'b0, 1'b0, 8'h77, 8'h11);
        @(posedge clk);
        #1 start = 1'b0;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy || done || SS != 3'b111) cnt++;
        end
        check_eq("bad_sel_ignored", cnt, 0);

        // Back-to-back transfers.
        start_xfer(2'd0, 1'b0, 1'b0, 8'h01, 8'h5A);
        wait_done(2'd0, 1'b0, 8'h01, 8'h5A, 1'b0);
        start_xfer(2'd2, 1'b1, 1'b1, 8'h80, 8'hC3);
        wait_done(2'd2, 1'b1, 8'h80, 8'hC3, 1'b0);
        repeat (2) @(negedge clk);

        // Reset in the middle of a transfer.
        start_xfer(2'd0, 1'b1, 1'b0, 8'hA5, 8'h3C);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("mid_busy", busy, 1);
        rst = 1'b0;
        #1;
        check_eq("abort_ss", SS, 3'b111);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_sclk", SCLK, 0);
        check_eq("abort_rx", rx_data, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check_eq("abort_no_done", cnt, 0);
        start_xfer(2'd1, 1'b0, 1'b1, 8'h3C, 8'hA5);
        wait_done(2'd1, 1'b0, 8'h3C, 8'hA5, 1'b0);
        repeat (2) @(negedge clk);

        // Randomized transfers.
        for (int k = 0; k < 8; k++) begin
            logic [1:0] sel;
            logic       pol, pha;
            logic [7:0] tx, sw;
            sel = 2'($urandom_range(0, NUM_SS - 1));
            pol = 1'($urandom);
            pha = 1'($urandom);
            tx  = 8'($urandom);
            sw  = 8'($urandom);
            start_xfer(sel, pol, pha, tx, sw);
            wait_done(sel, pol, tx, sw, 1'b0);
            repeat (1 + $urandom_range(0, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
